// File: rtl/rc5_core_arbiter.sv
// rtl/rc5_core_arbiter.sv - round-robin arbiter sharing one iterative RC5 core between two requesters.
// Optional BUSY watchdog enabled by defining RC5_ARB_TIMEOUT_EN.
module rc5_core_arbiter #(
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0,
  input  logic         mode0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  output logic         ack0,
  output logic         rvalid0,
  input  logic         req1,
  input  logic         mode1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack1,
  output logic         rvalid1,
  output logic [W-1:0] rdata_a,
  output logic [W-1:0] rdata_b,
  output logic         err,
  output logic         busy,
  output logic         core_start,
  output logic         core_mode,
  output logic [W-1:0] core_a,
  output logic [W-1:0] core_b,
  input  logic         core_done,
  input  logic [W-1:0] core_res_a,
  input  logic [W-1:0] core_res_b
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;

  state_t state, state_next;
  logic   owner;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_sel;

`ifdef RC5_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_hit;

  // A done arriving in the same cycle as expiry takes priority over the abort.
  assign tmo_hit = (state == BUSY) && !core_done && (tmo_cnt == 16'(TIMEOUT - 1));
`else
  assign err = 1'b0;
`endif

  // On a tie, the requester that was not served last wins.
  assign grant_valid = req0 | req1;
  assign grant_sel   = (req0 && req1) ? ~last_grant : req1;

  always_comb begin
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    core_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant_valid) state_next = LAUNCH;
      end
      LAUNCH: begin
        ack0       = ~owner;
        ack1       = owner;
        core_start = 1'b1;
        state_next = BUSY;
      end
      BUSY: begin
        if (core_done) state_next = RESP;
`ifdef RC5_ARB_TIMEOUT_EN
        else if (tmo_hit) state_next = RESP;
`endif
      end
      RESP: begin
        rvalid0    = ~owner;
        rvalid1    = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      core_mode  <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      rdata_a    <= '0;
      rdata_b    <= '0;
`ifdef RC5_ARB_TIMEOUT_EN
      err        <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_sel;
            core_mode <= grant_sel ? mode1 : mode0;
            core_a    <= grant_sel ? a1 : a0;
            core_b    <= grant_sel ? b1 : b0;
          end
        end
        LAUNCH: begin
`ifdef RC5_ARB_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        BUSY: begin
          if (core_done) begin
            rdata_a <= core_res_a;
            rdata_b <= core_res_b;
`ifdef RC5_ARB_TIMEOUT_EN
            err     <= 1'b0;
          end else if (tmo_hit) begin
            rdata_a <= '0;
            rdata_b <= '0;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
`endif
          end
        end
        RESP: begin
          last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_core_arbiter.sv
// tb/tb_rc5_core_arbiter.sv - directed self-checking bench for rc5_core_arbiter.
module tb_rc5_core_arbiter;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0, mode0, req1, mode1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, rvalid0, ack1, rvalid1;
  logic [W-1:0] rdata_a, rdata_b;
  logic         err, busy, core_start, core_mode;
  logic [W-1:0] core_a, core_b;
  logic         core_done;
  logic [W-1:0] core_res_a, core_res_b;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  rc5_core_arbiter #(.W(W), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .mode0(mode0), .a0(a0), .b0(b0), .ack0(ack0), .rvalid0(rvalid0),
    .req1(req1), .mode1(mode1), .a1(a1), .b1(b1), .ack1(ack1), .rvalid1(rvalid1),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .err(err), .busy(busy),
    .core_start(core_start), .core_mode(core_mode), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_res_a(core_res_a), .core_res_b(core_res_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one cycle; inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic done_pulse(input logic [W-1:0] ra, input logic [W-1:0] rb);
    core_done  = 1'b1;
    core_res_a = ra;
    core_res_b = rb;
    tick();
    core_done  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {req0, mode0, req1, mode1, core_done} = '0;
    {a0, b0, a1, b1, core_res_a, core_res_b} = '0;
    tick();
    tick();
    check("reset_ctl", {ack0, ack1, rvalid0, rvalid1, err, busy, core_start, core_mode}, 0);
    check("reset_data", {core_a, core_b, rdata_a, rdata_b}, 0);
    reset = 1'b0;
    tick();

    // Single job, core answers five cycles after start.
    req0 = 1'b1; mode0 = 1'b1; a0 = 8'h0a; b0 = 8'h0b;
    check("single_no_early_ack", ack0, 0);
    tick();
    check("single_ack", {ack0, ack1, core_start}, 3'b101);
    check("single_core_ops", {core_mode, core_a, core_b}, {1'b1, 8'h0a, 8'h0b});
    check("single_busy", busy, 1);
    req0 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("single_wait", {ack0, core_start, rvalid0, rvalid1, busy}, 5'b00001);
    end
    tick();
    done_pulse(8'hf5, 8'h84);
    check("single_rvalid", {rvalid0, rvalid1, err}, 3'b100);
    check("single_rdata", {rdata_a, rdata_b}, 16'hf584);
    tick();
    check("single_idle", {rvalid0, rvalid1, busy}, 0);
    check("single_hold", {rdata_a, rdata_b}, 16'hf584);

    // Tie after reset: requester 0 first, requester 1 at done+3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    req0 = 1'b1; mode0 = 1'b0; a0 = 8'h11; b0 = 8'h22;
    req1 = 1'b1; mode1 = 1'b1; a1 = 8'h33; b1 = 8'h44;
    tick();
    check("tie_ack0", {ack0, ack1}, 2'b10);
    check("tie_ops0", {core_mode, core_a, core_b}, {1'b0, 8'h11, 8'h22});
    req0 = 1'b0;
    tick();
    done_pulse(8'h55, 8'h66);
    check("tie_rvalid0", {rvalid0, rvalid1}, 2'b10);
    check("tie_rdata0", {rdata_a, rdata_b}, 16'h5566);
    tick();
    check("tie_idle", {ack1, busy}, 2'b00);
    tick();
    check("tie_ack1", {ack0, ack1, core_start}, 3'b011);
    check("tie_ops1", {core_mode, core_a, core_b}, {1'b1, 8'h33, 8'h44});
    req1 = 1'b0;
    tick();
    done_pulse(8'h77, 8'h88);
    check("tie_rvalid1", {rvalid0, rvalid1}, 2'b01);
    check("tie_rdata1", {rdata_a, rdata_b}, 16'h7788);
    tick();

    // Fairness: both requesters held for four jobs.
    req0 = 1'b1; req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("fair_ack", {ack0, ack1}, (j % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      done_pulse(8'(8'h20 + j), 8'(8'h40 + j));
      check("fair_rvalid", {rvalid0, rvalid1}, (j % 2 == 0) ? 2'b10 : 2'b01);
      check("fair_rdata", {rdata_a, rdata_b}, {8'(8'h20 + j), 8'(8'h40 + j)});
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Spurious done in IDLE and in LAUNCH.
    done_pulse(8'h99, 8'h99);
    check("spur_idle", {busy, rvalid0, rvalid1}, 0);
    check("spur_idle_data", {rdata_a, rdata_b}, 16'h2343);
    req0 = 1'b1; mode0 = 1'b1; a0 = 8'h5a; b0 = 8'ha5;
    tick();
    check("spur_ack", ack0, 1);
    req0 = 1'b0;
    done_pulse(8'h99, 8'h99);
    check("spur_launch", {busy, rvalid0, core_start}, 3'b100);
    tick();
    check("spur_still_busy", {busy, rvalid0}, 2'b10);
    done_pulse(8'hab, 8'hcd);
    check("spur_rvalid", {rvalid0, err}, 2'b10);
    check("spur_rdata", {rdata_a, rdata_b}, 16'habcd);
    tick();

    // Reset during BUSY, then a stale done.
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_ctl", {ack0, ack1, rvalid0, rvalid1, err, busy, core_start, core_mode}, 0);
    check("rst_mid_data", {core_a, core_b, rdata_a, rdata_b}, 0);
    done_pulse(8'h12, 8'h34);
    check("rst_stale_done", {rvalid0, rvalid1, busy}, 0);

`ifdef RC5_ARB_TIMEOUT_EN
    // Watchdog abort after 16 BUSY cycles, then a normal job.
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
    tick();
    req0 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("tmo_wait", {busy, rvalid0}, 2'b10);
    end
    tick();
    check("tmo_rvalid", {rvalid0, err}, 2'b11);
    check("tmo_rdata", {rdata_a, rdata_b}, 0);
    tick();
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    done_pulse(8'hc3, 8'h3c);
    check("tmo_next_rvalid", {rvalid0, err}, 2'b10);
    check("tmo_next_rdata", {rdata_a, rdata_b}, 16'hc33c);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rc5_core_arbiter.md
Name: rc5_core_arbiter

Overview:
- Shares one iterative RC5 encrypt/decrypt core (8-bit A/B halves, start/done handshake) between two requesters.
- Arbitrates round-robin, latches the winner's operands and mode, and pulses the core start.
- Waits for core done, then returns the result to the owning requester.
- Sits between the two crypto clients and the single RC5 engine instance.

Parameters:
- W, 8: width of each data half (A, B).
- TIMEOUT, 255: cycles in BUSY before a job is aborted (used only with RC5_ARB_TIMEOUT_EN); range 1..65535.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 job request; held until ack0.
- mode0  in  1  requester 0 operation: 1 = encrypt, 0 = decrypt.
- a0, b0  in  W  requester 0 plaintext/ciphertext halves.
- ack0  out  1  one-cycle pulse: requester 0's job accepted, operands captured.
- rvalid0  out  1  one-cycle pulse: result for requester 0 on rdata_a/rdata_b.
- req1, mode1, a1, b1, ack1, rvalid1: same as above, for requester 1.
- rdata_a, rdata_b  out  W  result halves, shared by both requesters.
- err  out  1  qualifies rvalidN; 1 = job aborted.
- busy  out  1  1 in any state other than IDLE.
- core_start  out  1  one-cycle start pulse to the core.
- core_mode  out  1  operation sent to the core.
- core_a, core_b  out  W  operands sent to the core.
- core_done  in  1  core result valid (single-cycle pulse or level).
- core_res_a, core_res_b  in  W  core result halves.

Behaviour:
- Reset (synchronous): state = IDLE; all outputs = 0; last-grant pointer = 1, so requester 0 wins the first tie; timeout counter = 0. Reset mid-job abandons the job without signalling it: no rvalid, and core_done is ignored until a new LAUNCH. The core shares the same reset.
- States: IDLE, LAUNCH, BUSY, RESP.
- IDLE:
  - No req: stay.
  - Exactly one req: grant it.
  - Both req: grant the requester not equal to the last-grant pointer.
  - On grant, latch modeN/aN/bN into core_mode/core_a/core_b, record the owner, go to LAUNCH.
- LAUNCH (one cycle): ackN = 1 for the owner, core_start = 1; go to BUSY. core_done is ignored in this cycle.
- BUSY:
  - core_start = 0. core_mode/core_a/core_b stay stable from LAUNCH until the next grant.
  - On core_done = 1: capture core_res_a/b into rdata_a/b, set err = 0, go to RESP.
- RESP (one cycle): rvalidN = 1 for the owner only; last-grant pointer = owner; go to IDLE.
  - rdata_a/b and err hold their values until the next RESP.
- Timing, with req sampled in IDLE at cycle t:
  - ack and core_start at t+1.
  - core_done sampled at d ≥ t+2 gives rvalid at d+1.
  - IDLE again at d+2; the earliest next ack is d+3.
- Requester rules:
  - Drop req (or present a new job) in the cycle after ack.
  - A req still high when IDLE is re-entered counts as a new job.
  - The non-granted requester's req is simply held pending; it is never lost or reordered.
- ackN and rvalidN are never asserted for both requesters in the same cycle.
- busy = 0 only in IDLE.
- core_done while in IDLE or RESP is ignored.

Optional Feature:
- Macro: RC5_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no core_done, go to RESP with err = 1 and rdata_a/b = 0.
  - core_done in the same cycle as the timeout wins: normal result, err = 0.
- When undefined: BUSY waits indefinitely, err is tied to 0, and no counter logic is present.

Test Plan:
- Single job: req0=1, mode0=1, a0=0x0a, b0=0x0b; core model returns 0xf5/0x84 five cycles after start -> ack0 and core_start together at t+1 for one cycle with core_mode=1, core_a=0x0a, core_b=0x0b; rvalid0 one cycle after done with rdata 0xf5/0x84, err=0; rvalid1 never asserted.
- Tie after reset: req0 and req1 both asserted at the same cycle -> requester 0 served first; ack1 follows at done+3; rvalid1 carries requester 1's result.
- Fairness: both requesters hold req continuously for 4 jobs -> grant order 0,1,0,1; no ack overlap.
- Spurious done: core_done asserted in the LAUNCH cycle and while in IDLE -> no state change, no rvalid; the real done later completes normally.
- Reset mid-job: reset during BUSY, then core_done -> all outputs 0 on the cycle after reset; no rvalid; busy=0.
- With RC5_ARB_TIMEOUT_EN, TIMEOUT=16, core never signals done -> rvalid0 with err=1 and rdata 0x00/0x00 after 16 BUSY cycles; the next job then proceeds normally with err=0.
